// File: rtl/dmem_port.sv
// MEM-stage data-memory port: one request/ack bus transaction per access, stalls the pipe,
// and returns aligned/extended load data. Optional REQ timeout via DMEM_TIMEOUT_EN.
module dmem_port #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_chip_sel,
    input  logic              mem_load,
    input  logic              mem_byte_op,
    input  logic              mem_half_op,
    input  logic              mem_unsigned_op,
    input  logic [1:0]        mem_rotate_amount,
    input  logic [3:0]        mem_byte_enable,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_store_data,
    output logic              stall,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ack,
    input  logic              dbus_err,
    input  logic [31:0]       dbus_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic              fault,
    output logic              fault_timeout
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_load, r_byte, r_half, r_unsigned, r_we;
    logic [1:0]          r_rot;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata, r_wb_data;
    logic                r_wb_valid, r_fault, r_fault_to;
    logic                w_resp, w_timeout, w_unused;
    logic [31:0]         w_wdata_rot, w_shifted, w_aligned;

    assign w_resp = dbus_ack | dbus_err;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_cnt;

    // Held at zero outside REQ, so it is clear on every REQ entry.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state != S_REQ)
            r_cnt <= '0;
        else if (!w_resp)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_timeout = (r_state == S_REQ) && !w_resp && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_unused  = &{1'b0, mem_addr[1:0]};
`else
    assign w_timeout = 1'b0;
    assign w_unused  = &{1'b0, mem_addr[1:0], (TIMEOUT_CYCLES != 0)};
`endif

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = mem_chip_sel;
                if (mem_chip_sel) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                stall = 1'b1;
                if (w_resp || w_timeout) w_state_nxt = S_DONE;
            end
            // chip_sel still shows the finished instruction here, so it is not looked at
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wdata_rot = mem_store_data;
        case (mem_rotate_amount)
            2'd1:    w_wdata_rot = {mem_store_data[23:0], mem_store_data[31:24]};
            2'd2:    w_wdata_rot = {mem_store_data[15:0], mem_store_data[31:16]};
            2'd3:    w_wdata_rot = {mem_store_data[7:0],  mem_store_data[31:8]};
            default: w_wdata_rot = mem_store_data;
        endcase
    end

    assign w_shifted = dbus_rdata >> {r_rot, 3'b000};

    always_comb begin
        w_aligned = w_shifted;
        if (r_byte)
            w_aligned = r_unsigned ? {24'h0, w_shifted[7:0]} : {{24{w_shifted[7]}}, w_shifted[7:0]};
        else if (r_half)
            w_aligned = r_unsigned ? {16'h0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_load     <= 1'b0;
            r_byte     <= 1'b0;
            r_half     <= 1'b0;
            r_unsigned <= 1'b0;
            r_rot      <= 2'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'h0;
            r_wdata    <= 32'h0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'h0;
            r_fault    <= 1'b0;
            r_fault_to <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wb_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_to <= 1'b0;
            if (r_state == S_IDLE && mem_chip_sel) begin
                r_load     <= mem_load;
                r_byte     <= mem_byte_op;
                r_half     <= mem_half_op;
                r_unsigned <= mem_unsigned_op;
                r_rot      <= mem_rotate_amount;
                r_we       <= ~mem_load;
                r_addr     <= {mem_addr[ADDR_W-1:2], 2'b00};
                r_be       <= mem_load ? 4'hF : mem_byte_enable;
                r_wdata    <= w_wdata_rot;
            end
            if (r_state == S_REQ) begin
                if (dbus_err) begin
                    r_fault <= 1'b1;
                end else if (dbus_ack) begin
                    if (r_load) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= w_aligned;
                    end
                end else if (w_timeout) begin
                    r_fault    <= 1'b1;
                    r_fault_to <= 1'b1;
                end
            end
        end
    end

    assign dbus_req      = (r_state == S_REQ);
    assign dbus_we       = r_we;
    assign dbus_addr     = r_addr;
    assign dbus_be       = r_be;
    assign dbus_wdata    = r_wdata;
    assign wb_valid      = r_wb_valid;
    assign wb_data       = r_wb_data;
    assign fault         = r_fault;
    assign fault_timeout = r_fault_to;

endmodule

// File: tb/tb_dmem_port.sv
// Bench for dmem_port: directed cases plus random accesses against a transaction-level model.
module tb_dmem_port;
    localparam int ADDR_W = 32;
    localparam int TO_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_chip_sel, mem_load, mem_byte_op, mem_half_op, mem_unsigned_op;
    logic [1:0]        mem_rotate_amount;
    logic [3:0]        mem_byte_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_store_data;
    logic              stall, dbus_req, dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [3:0]        dbus_be;
    logic [31:0]       dbus_wdata;
    logic              dbus_ack, dbus_err;
    logic [31:0]       dbus_rdata;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic              fault, fault_timeout;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_wb;

    always #5 clk = ~clk;

    dmem_port #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_chip_sel(mem_chip_sel), .mem_load(mem_load), .mem_byte_op(mem_byte_op),
        .mem_half_op(mem_half_op), .mem_unsigned_op(mem_unsigned_op),
        .mem_rotate_amount(mem_rotate_amount), .mem_byte_enable(mem_byte_enable),
        .mem_addr(mem_addr), .mem_store_data(mem_store_data),
        .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
        .dbus_rdata(dbus_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .fault(fault), .fault_timeout(fault_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rotl(input logic [31:0] d, input logic [1:0] r);
        logic [63:0] t;
        t = {d, d} << (8 * r);
        return t[63:32];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] r,
                                             input bit b, input bit h, input bit u);
        logic [31:0] s;
        s = rd >> (8 * r);
        if (b) return u ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        if (h) return u ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return s;
    endfunction

    task automatic drive(input bit ld, input bit b, input bit h, input bit u, input logic [1:0] rot,
                         input logic [3:0] be, input logic [31:0] addr, input logic [31:0] sd);
        mem_chip_sel = 1'b1; mem_load = ld; mem_byte_op = b; mem_half_op = h;
        mem_unsigned_op = u; mem_rotate_amount = rot; mem_byte_enable = be;
        mem_addr = addr; mem_store_data = sd;
    endtask

    // One full access: issue, hold for 'waits' empty REQ cycles, respond, check DONE and after.
    task automatic xact(input string nm, input bit ld, input bit b, input bit h, input bit u,
                        input logic [1:0] rot, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        input bit ak, input bit er);
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        bit          e_valid;
        int          st;
        e_addr = {addr[31:2], 2'b00};
        e_be   = ld ? 4'hF : be;
        e_wd   = ref_rotl(sd, rot);
        @(negedge clk);
        drive(ld, b, h, u, rot, be, addr, sd);
        #1 chk({nm, "/stall0"}, stall, 1);
        st = 1;
        @(negedge clk);
        for (int i = 0; i <= waits; i++) begin
            chk({nm, "/req"}, dbus_req, 1);
            chk({nm, "/addr"}, dbus_addr, e_addr);
            chk({nm, "/we"}, dbus_we, !ld);
            chk({nm, "/be"}, dbus_be, e_be);
            chk({nm, "/wdata"}, dbus_wdata, e_wd);
            if (stall) st++;
            mem_addr = $urandom; mem_store_data = $urandom; mem_byte_enable = 4'($urandom);
            mem_rotate_amount = 2'($urandom);
            dbus_ack   = (i == waits) ? ak : 1'b0;
            dbus_err   = (i == waits) ? er : 1'b0;
            dbus_rdata = (i == waits) ? rd : $urandom;
            @(negedge clk);
        end
        e_valid = ld && ak && !er;
        if (e_valid) m_wb = ref_load(rd, rot, b, h, u);
        chk({nm, "/stall_len"}, st, waits + 2);
        chk({nm, "/done_stall"}, stall, 0);
        chk({nm, "/done_req"}, dbus_req, 0);
        chk({nm, "/wb_valid"}, wb_valid, e_valid);
        chk({nm, "/wb_data"}, wb_data, m_wb);
        chk({nm, "/fault"}, fault, er);
        chk({nm, "/fault_to"}, fault_timeout, 0);
        dbus_ack = 1'b0; dbus_err = 1'b0; mem_chip_sel = 1'b0;
        @(negedge clk);
        chk({nm, "/post_valid"}, wb_valid, 0);
        chk({nm, "/post_fault"}, fault, 0);
        chk({nm, "/post_req"}, dbus_req, 0);
        chk({nm, "/post_wb"}, wb_data, m_wb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bit ld, b, h, u, ak, er;
        int sz, rsp, w;
        logic [1:0]  rot;
        logic [31:0] a;

        rst_n = 1'b0; mem_chip_sel = 1'b0; mem_load = 1'b0; mem_byte_op = 1'b0;
        mem_half_op = 1'b0; mem_unsigned_op = 1'b0; mem_rotate_amount = 2'd0;
        mem_byte_enable = 4'h0; mem_addr = '0; mem_store_data = 32'h0;
        dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = 32'h0;
        m_wb = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst/stall", stall, 0);
        chk("rst/req", dbus_req, 0);
        chk("rst/we", dbus_we, 0);
        chk("rst/addr", dbus_addr, 0);
        chk("rst/be", dbus_be, 0);
        chk("rst/wdata", dbus_wdata, 0);
        chk("rst/wb_valid", wb_valid, 0);
        chk("rst/wb_data", wb_data, 0);
        chk("rst/fault", fault, 0);
        chk("rst/fault_to", fault_timeout, 0);
        rst_n = 1'b1;

        xact("lb", 1, 1, 0, 0, 2'd1, 4'h0, 32'h0000_1001, 32'h0, 32'h1234_F678, 0, 1, 0);
        chk("lb/const", wb_data, 32'hFFFF_FFF6);
        chk("lb/addr_const", dbus_addr, 32'h0000_1000);
        xact("sh", 0, 0, 1, 0, 2'd2, 4'b1100, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 1, 0);
        chk("sh/wdata_const", dbus_wdata, 32'hBEEF_0000);
        chk("sh/be_const", dbus_be, 4'b1100);
        xact("lhu", 1, 0, 1, 1, 2'd2, 4'h0, 32'h0000_3002, 32'h0, 32'h8001_ABCD, 3, 1, 0);
        chk("lhu/const", wb_data, 32'h0000_8001);
        xact("ackerr", 1, 0, 0, 0, 2'd0, 4'h0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1, 1, 1);
        chk("ackerr/hold", wb_data, 32'h0000_8001);

        // Reset lands in REQ, then a stale ack shows up in IDLE.
        @(negedge clk);
        drive(1, 0, 0, 0, 2'd0, 4'h0, 32'h0000_5004, 32'h0);
        @(negedge clk);
        chk("rstreq/req_pre", dbus_req, 1);
        rst_n = 1'b0; mem_chip_sel = 1'b0;
        @(negedge clk);
        m_wb = 32'h0;
        chk("rstreq/req", dbus_req, 0);
        chk("rstreq/stall", stall, 0);
        chk("rstreq/wb_data", wb_data, 0);
        rst_n = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rstreq/late_valid", wb_valid, 0);
        chk("rstreq/late_req", dbus_req, 0);
        chk("rstreq/late_stall", stall, 0);
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("rstreq/idle_valid", wb_valid, 0);
        chk("rstreq/idle_wb", wb_data, 0);

        // Unanswered request.
        @(negedge clk);
        drive(1, 0, 0, 0, 2'd0, 4'h0, 32'h0000_0040, 32'h0);
        @(negedge clk);
`ifdef DMEM_TIMEOUT_EN
        for (int i = 0; i < TO_CYC; i++) begin
            chk("to/req", dbus_req, 1);
            chk("to/fault_early", fault, 0);
            @(negedge clk);
        end
        chk("to/fault", fault, 1);
        chk("to/fault_to", fault_timeout, 1);
        chk("to/req_drop", dbus_req, 0);
        chk("to/stall", stall, 0);
        chk("to/wb_valid", wb_valid, 0);
        chk("to/wb_hold", wb_data, m_wb);
        mem_chip_sel = 1'b0;
        @(negedge clk);
        chk("to/fault_pulse", fault, 0);
`else
        repeat (100) @(negedge clk);
        chk("hang/req", dbus_req, 1);
        chk("hang/stall", stall, 1);
        chk("hang/fault", fault, 0);
        dbus_ack = 1'b1; dbus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        m_wb = 32'h0BAD_F00D;
        chk("hang/wb_valid", wb_valid, 1);
        chk("hang/wb_data", wb_data, m_wb);
        chk("hang/fault_to", fault_timeout, 0);
        dbus_ack = 1'b0; mem_chip_sel = 1'b0;
        @(negedge clk);
`endif

        repeat (60) begin
            ld  = bit'($urandom_range(0, 1));
            sz  = $urandom_range(0, 2);
            b   = (sz == 0);
            h   = (sz == 1);
            u   = bit'($urandom_range(0, 1));
            a   = $urandom;
            rot = 2'($urandom);
            w   = $urandom_range(0, 3);
            rsp = $urandom_range(0, 5);
            ak  = (rsp != 4);
            er  = (rsp >= 4);
            xact("rnd", ld, b, h, u, rot, 4'($urandom), a, $urandom, $urandom, w, ak, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory port for the MEM stage. Consumes the registered load/store controls from the load/store control logic, runs one request/acknowledge transaction on the data bus, stalls the pipeline until the bus completes, and returns aligned, sign- or zero-extended load data to writeback. One access is in flight at a time.

## Interface

Parameters:
- `ADDR_W`, 32, data bus address width.
- `TIMEOUT_CYCLES`, 16, REQ-state cycles without response before a timeout fault. Used only when `DMEM_TIMEOUT_EN` is defined.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `mem_chip_sel` input 1: access present in MEM.
- `mem_load` input 1: 1 = load, 0 = store (valid with `mem_chip_sel`).
- `mem_byte_op`, `mem_half_op`, `mem_unsigned_op` input 1 each: access size and extension.
- `mem_rotate_amount` input 2: byte-lane rotation.
- `mem_byte_enable` input 4: store lane enables.
- `mem_addr` input ADDR_W: effective address.
- `mem_store_data` input 32: unrotated store data, LSB-justified.
- `stall` output 1: holds IF through MEM.
- `dbus_req` output 1: bus request.
- `dbus_we` output 1: write.
- `dbus_addr` output ADDR_W: word-aligned address `{mem_addr[ADDR_W-1:2],2'b00}`.
- `dbus_be` output 4: lane enables.
- `dbus_wdata` output 32: lane-aligned store data.
- `dbus_ack` input 1: transfer complete.
- `dbus_err` input 1: transfer failed.
- `dbus_rdata` input 32: read word, valid with `dbus_ack`.
- `wb_valid` output 1: load result valid (one-cycle pulse).
- `wb_data` output 32: aligned, extended load result.
- `fault` output 1: bus error or timeout (one-cycle pulse).
- `fault_timeout` output 1: the fault is a timeout (pulses with `fault`).

## Operation

States: IDLE, REQ, DONE.
- **IDLE:**
  - `stall = mem_chip_sel` (combinational).
  - If `mem_chip_sel`, latch the access: `dbus_addr`, `dbus_we = ~mem_load`, size/unsigned flags, and rotation.
  - Store lanes: `dbus_be = mem_byte_enable`. Loads: `dbus_be = 4'hF`.
  - Store data: `dbus_wdata = mem_store_data` rotated left by 8×`mem_rotate_amount` bits. Go to REQ.
- **REQ:**
  - `dbus_req = 1`; all `dbus_*` outputs stay stable; `stall = 1`.
  - `dbus_err` goes to DONE with a fault. `dbus_err` wins over a simultaneous `dbus_ack`.
  - Otherwise `dbus_ack` goes to DONE. On a load, register the aligned result into `wb_data`.
- **DONE:**
  - `stall = 0`, so the pipeline advances this cycle.
  - `wb_valid = 1` for one cycle if the access was a load without a fault.
  - `fault` pulses if flagged.
  - `mem_chip_sel` is ignored in DONE because it still reflects the completed instruction. Go to IDLE.
- **Load alignment:**
  - `s = dbus_rdata >> (8×rotate)`.
  - Byte: take `s[7:0]`. Half: take `s[15:0]`.
  - Zero-extend if unsigned, else sign-extend. Word: `s` unchanged.
- **Faulted loads:** `wb_data` keeps its previous value and `wb_valid` stays 0.
- **Holding:** `wb_data` holds between loads. `dbus_req` is 0 outside REQ.
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Reset mid-transaction:** return to IDLE and drop `dbus_req` on the reset edge. A late `dbus_ack` in IDLE is ignored.

## Timing

- Zero-wait bus:
  - Cycle 0: `mem_chip_sel` in IDLE, `stall = 1`.
  - Cycle 1: REQ, ack arrives.
  - Cycle 2: DONE, `wb_valid = 1`, `stall = 0`.
- Minimum stall is 2 cycles. Each bus wait state adds one cycle.
- `wb_valid`, `wb_data`, and `fault` are registered, so they are valid in DONE.
- `stall` is the only combinational output.

## Configuration

- **`DMEM_TIMEOUT_EN` defined:**
  - A counter clears on entry to REQ and increments each REQ cycle without ack or err.
  - On the cycle it reaches `TIMEOUT_CYCLES - 1` with no response, go to DONE with `fault = 1` and `fault_timeout = 1`. `dbus_req` drops there.
  - A response on that same cycle takes priority over the timeout.
- **Not defined:**
  - No counter; REQ waits indefinitely.
  - `fault_timeout` is tied to 0.

## Test plan

- **Load byte, signed:** LB at addr `0x1001`, `dbus_rdata = 0x1234F678`, zero-wait.
  - `dbus_addr = 0x1000`, `dbus_be = 4'hF`.
  - Cycle 2: `wb_valid = 1`, `wb_data = 0xFFFFFFF6`.
  - Stall high for cycles 0–1.
- **Store half:** SH at addr `0x2002`, data `0x0000BEEF`, rotate 2, be `4'b1100`.
  - `dbus_we = 1`, `dbus_wdata = 0xBEEF0000`, `dbus_be = 4'b1100`.
  - `wb_valid` stays 0.
- **Load half unsigned, 3 wait states:** LHU addr `0x3002`, rdata `0x8001ABCD`, ack 3 cycles late.
  - Stall for 5 cycles; `wb_data = 0x00008001`; `dbus_*` stable throughout REQ.
- **Simultaneous ack and err on a load:**
  - `fault = 1` for one cycle in DONE; `wb_valid = 0`; `wb_data` unchanged.
- **Reset mid-REQ:** `rst_n = 0` for one edge during REQ, then ack.
  - `dbus_req = 0`, state IDLE, no `wb_valid`, `stall = 0`.
- **Timeout (`DMEM_TIMEOUT_EN`, `TIMEOUT_CYCLES = 4`):** no response.
  - `fault` and `fault_timeout` pulse after 4 REQ cycles; `dbus_req` drops.
  - Without the macro, `dbus_req` is still high after 100 cycles.
